// File: rtl/ethernet_frame_tx.sv
// Ethernet II frame transmitter: preamble/SFD, header, payload with zero padding,
// CRC-32 FCS and inter-frame gap, serialised LSB-first as N-bit symbols.
module ethernet_frame_tx #(
  parameter int unsigned N           = 2,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IFG_BYTES   = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   axiid,
  input  logic         axiiv,
  input  logic         axiil,
  output logic         axiir,
  input  logic [47:0]  my_mac,
  input  logic [47:0]  dest_mac,
  input  logic [15:0]  etype,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         busy,
  output logic         underrun
);

  localparam int unsigned Spb    = 8 / N;
  localparam int unsigned SymW   = $clog2(Spb);
  localparam int unsigned CntW   = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned IfgCyc = IFG_BYTES * Spb;
  localparam int unsigned IfgW   = $clog2(IfgCyc + 1);
  localparam logic [SymW-1:0] SymLast = SymW'(Spb - 1);
  localparam logic [7:0] PreByte = 8'h55;
  localparam logic [7:0] SfdByte = 8'hD5;

  typedef enum logic [2:0] {
    StIdle, StPreamble, StSfd, StHeader, StPayload, StPad, StFcs, StIfg
  } state_e;

  state_e          state_q, state_d;
  logic [SymW-1:0] sym_q, sym_d, next_sym;
  logic [3:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [7:0]      cur_q, cur_d, nb;
  logic [31:0]     crc_q, crc_d;
  logic [111:0]    hdr_q, hdr_d;
  logic [IfgW-1:0] ifg_q, ifg_d;
  logic            busy_q, busy_d, axiov_q, axiov_d, axiir_q, axiir_d;
  logic            underrun_q, underrun_d;
  logic [N-1:0]    axiod_q, axiod_d;
  logic            load, upd, accept, end_pl;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    sym_d      = sym_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    cur_d      = cur_q;
    crc_d      = crc_q;
    hdr_d      = hdr_q;
    ifg_d      = ifg_q;
    busy_d     = busy_q;
    axiov_d    = axiov_q;
    axiod_d    = axiod_q;
    underrun_d = 1'b0;
    load       = 1'b0;
    upd        = 1'b0;
    accept     = 1'b0;
    end_pl     = 1'b0;
    nb         = 8'h00;
    next_sym   = sym_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (axiiv) begin
          state_d = StPreamble;
          idx_d   = 4'd0;
          cnt_d   = '0;
          done_d  = 1'b0;
          crc_d   = '1;
          hdr_d   = {dest_mac, my_mac, etype};
          busy_d  = 1'b1;
          axiov_d = 1'b1;
          cur_d   = PreByte;
          sym_d   = '0;
          axiod_d = PreByte[N-1:0];
        end
      end
      StIfg: begin
        if (ifg_q == IfgW'(IfgCyc - 1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          ifg_d = ifg_q + 1'b1;
        end
      end
      default: begin
        if (sym_q != SymLast) begin
          sym_d   = next_sym;
          axiod_d = cur_q[next_sym*N +: N];
        end else begin
          load = 1'b1;
          case (state_q)
            StPreamble: begin
              if (idx_q == 4'd6) begin
                state_d = StSfd;
                nb      = SfdByte;
              end else begin
                idx_d = idx_q + 4'd1;
                nb    = PreByte;
              end
            end
            StSfd: begin
              state_d = StHeader;
              idx_d   = 4'd0;
              nb      = hdr_q[111:104];
              hdr_d   = hdr_q << 8;
              upd     = 1'b1;
            end
            StHeader: begin
              if (idx_q != 4'd13) begin
                idx_d = idx_q + 4'd1;
                nb    = hdr_q[111:104];
                hdr_d = hdr_q << 8;
                upd   = 1'b1;
              end else if (axiiv) begin
                accept = 1'b1;
              end else begin
                underrun_d = 1'b1;
                end_pl     = 1'b1;
              end
            end
            StPayload: begin
              if (done_q) begin
                end_pl = 1'b1;
              end else if (axiiv) begin
                accept = 1'b1;
              end else begin
                underrun_d = 1'b1;
                end_pl     = 1'b1;
              end
            end
            StPad: end_pl = 1'b1;
            StFcs: begin
              if (idx_q == 4'd3) begin
                state_d = StIfg;
                ifg_d   = '0;
                load    = 1'b0;
                axiov_d = 1'b0;
                axiod_d = '0;
              end else begin
                idx_d = idx_q + 4'd1;
                nb    = ~crc_q[7:0];
                crc_d = crc_q >> 8;
              end
            end
            default: ;
          endcase

          if (accept) begin
            state_d = StPayload;
            nb      = axiid;
            upd     = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            done_d  = axiil || (32'(cnt_q) + 32'd1 >= MAX_PAYLOAD);
          end
          // Pad bytes are counted in cnt so padding stops at MIN_PAYLOAD total.
          if (end_pl) begin
            if (32'(cnt_q) < MIN_PAYLOAD) begin
              state_d = StPad;
              nb      = 8'h00;
              upd     = 1'b1;
              cnt_d   = cnt_q + 1'b1;
            end else begin
              state_d = StFcs;
              idx_d   = 4'd0;
              nb      = ~crc_q[7:0];
              crc_d   = crc_q >> 8;
            end
          end
          if (load) begin
            cur_d   = nb;
            sym_d   = '0;
            axiod_d = nb[N-1:0];
            if (upd) crc_d = crc_byte(crc_q, nb);
          end
        end
      end
    endcase

    axiir_d = (sym_d == SymLast) &&
              ((state_d == StHeader && idx_d == 4'd13) || (state_d == StPayload && !done_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sym_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      cur_q      <= '0;
      crc_q      <= '1;
      hdr_q      <= '0;
      ifg_q      <= '0;
      busy_q     <= 1'b0;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
      axiir_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_q      <= sym_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      cur_q      <= cur_d;
      crc_q      <= crc_d;
      hdr_q      <= hdr_d;
      ifg_q      <= ifg_d;
      busy_q     <= busy_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
      axiir_q    <= axiir_d;
      underrun_q <= underrun_d;
    end
  end

  assign axiov    = axiov_q;
  assign axiod    = axiod_q;
  assign axiir    = axiir_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ethernet_frame_tx.sv
// Randomised bench for ethernet_frame_tx (N=4 and N=2 instances) against a byte-level
// frame model: preamble/SFD, header, payload, padding and software CRC-32.
module tb_ethernet_frame_tx;
  localparam int MinPl = 46;
  localparam int MaxPl = 1500;
  localparam int IfgBytes = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  axiid;
  logic        axiil, src_v;
  logic [47:0] my_mac, dest_mac;
  logic [15:0] etype;
  logic        v4, v2, r4, r2, ov4, ov2, b4, b2, u4, u2;
  logic [3:0]  d4;
  logic [1:0]  d2;
  logic        axiir_m, axiov_m, busy_m, underrun_m;
  logic [3:0]  axiod_m;
  int          sel = 0;
  int          checks = 0, errors = 0;

  assign v4         = src_v && (sel == 0);
  assign v2         = src_v && (sel == 1);
  assign axiir_m    = (sel == 1) ? r2 : r4;
  assign axiov_m    = (sel == 1) ? ov2 : ov4;
  assign busy_m     = (sel == 1) ? b2 : b4;
  assign underrun_m = (sel == 1) ? u2 : u4;
  assign axiod_m    = (sel == 1) ? {2'b00, d2} : d4;

  ethernet_frame_tx #(.N(4), .MIN_PAYLOAD(MinPl), .MAX_PAYLOAD(MaxPl), .IFG_BYTES(IfgBytes)) dut4 (
    .clk(clk), .rst(rst), .axiid(axiid), .axiiv(v4), .axiil(axiil), .axiir(r4),
    .my_mac(my_mac), .dest_mac(dest_mac), .etype(etype),
    .axiov(ov4), .axiod(d4), .busy(b4), .underrun(u4)
  );
  ethernet_frame_tx #(.N(2), .MIN_PAYLOAD(MinPl), .MAX_PAYLOAD(MaxPl), .IFG_BYTES(IfgBytes)) dut2 (
    .clk(clk), .rst(rst), .axiid(axiid), .axiiv(v2), .axiil(axiil), .axiir(r2),
    .my_mac(my_mac), .dest_mac(dest_mac), .etype(etype),
    .axiov(ov2), .axiod(d2), .busy(b2), .underrun(u2)
  );

  // Byte source: presents the queue head, pops on a handshake.
  logic [8:0] src_q[$];
  bit         src_en = 0;
  int         src_budget = 0;
  int         hs_cnt = 0;
  bit         src_hs;
  logic [8:0] src_tmp;
  initial begin
    src_v = 1'b0; axiid = 8'h00; axiil = 1'b0;
    forever begin
      @(negedge clk);
      src_hs = src_v && axiir_m && !rst;
      @(posedge clk);
      #1;
      if (src_hs && src_q.size() > 0) begin
        src_tmp = src_q.pop_front();
        hs_cnt++;
        src_budget--;
      end
      if (src_en && src_q.size() > 0 && src_budget > 0) begin
        src_v = 1'b1;
        {axiil, axiid} = src_q[0];
      end else begin
        src_v = 1'b0; axiil = 1'b0; axiid = 8'h00;
      end
    end
  end

  // Monitor: reassembles bytes, records frame lengths, gaps and underrun pulses.
  logic [7:0] cap_bytes[$];
  int         cap_len[$];
  int         gaps[$];
  int         und_cnt = 0, cur_len = 0, gap_cnt = 0, sh = 0;
  bit         prev_ov = 0, have_frame = 0;
  logic [7:0] acc = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (axiov_m) begin
        if (!prev_ov) begin
          if (have_frame) gaps.push_back(gap_cnt);
          cur_len = 0; sh = 0; acc = 8'h00;
        end
        cur_len++;
        acc = acc | (8'(axiod_m) << sh);
        sh += (sel == 1) ? 2 : 4;
        if (sh == 8) begin
          cap_bytes.push_back(acc);
          acc = 8'h00; sh = 0;
        end
      end else begin
        if (prev_ov) begin
          cap_len.push_back(cur_len);
          have_frame = 1;
          gap_cnt = 0;
        end
        gap_cnt++;
      end
      if (underrun_m) und_cnt++;
      prev_ov = axiov_m;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model
  logic [7:0] exp_pl[$];
  logic [7:0] exp_bytes[$];
  int         exp_len[$];

  task automatic add_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] e,
                           input int n);
    int start;
    logic [31:0] crc;
    logic fb;
    start = exp_bytes.size();
    repeat (7) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_bytes.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_bytes.push_back(s[47-8*i -: 8]);
    exp_bytes.push_back(e[15:8]);
    exp_bytes.push_back(e[7:0]);
    foreach (exp_pl[i]) exp_bytes.push_back(exp_pl[i]);
    for (int i = exp_pl.size(); i < MinPl; i++) exp_bytes.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    for (int i = start + 8; i < exp_bytes.size(); i++) begin
      for (int j = 0; j < 8; j++) begin
        fb  = crc[0] ^ exp_bytes[i][j];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) exp_bytes.push_back(crc[8*k +: 8]);
    exp_len.push_back((exp_bytes.size() - start) * 8 / n);
  endtask

  function automatic int first_diff();
    if (cap_bytes.size() != exp_bytes.size()) return -2;
    foreach (exp_bytes[i]) if (cap_bytes[i] !== exp_bytes[i]) return i;
    return -1;
  endfunction

  task automatic clear_all();
    cap_bytes.delete(); cap_len.delete(); gaps.delete();
    und_cnt = 0; have_frame = 0; hs_cnt = 0;
    exp_bytes.delete(); exp_len.delete(); exp_pl.delete();
  endtask

  task automatic load_payload(input int len, input bit with_last);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      exp_pl.push_back(b);
      src_q.push_back({with_last && (i == len - 1), b});
    end
  endtask

  task automatic rand_hdr();
    my_mac = {16'($urandom), 32'($urandom)};
    dest_mac = {16'($urandom), 32'($urandom)};
    etype = 16'($urandom);
  endtask

  task automatic go();
    src_budget = 1_000_000;
    src_en = 1;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (cap_len.size() >= n && !busy_m) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic stop_src();
    src_en = 0;
    src_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ov4, d4, r4, b4, u4} !== 8'h00) begin
      errors++;
      $display("FAIL reset_n4: got ov=%b d=%h r=%b busy=%b und=%b want all 0", ov4, d4, r4, b4, u4);
    end
    checks++;
    if ({ov2, d2, r2, b2, u2} !== 6'h00) begin
      errors++;
      $display("FAIL reset_n2: got ov=%b d=%h r=%b busy=%b und=%b want all 0", ov2, d2, r2, b2, u2);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_min_payload();
    bit ok;
    int d;
    sel = 0; clear_all(); rand_hdr();
    for (int i = 0; i < 46; i++) begin
      exp_pl.push_back(8'(i));
      src_q.push_back({i == 45, 8'(i)});
    end
    add_frame(dest_mac, my_mac, etype, 4);
    go();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (src_v) break;
    end
    checks++;
    if (axiov_m !== 1'b0) begin
      errors++; $display("FAIL pre_start_axiov: got %b want 0", axiov_m);
    end
    @(negedge clk);
    checks++;
    if ({axiov_m, busy_m, axiod_m} !== 6'b11_0101) begin
      errors++;
      $display("FAIL start_latency: got axiov=%b busy=%b axiod=%h want 1 1 5", axiov_m, busy_m,
               axiod_m);
    end
    rand_hdr();  // header fields must already be latched
    wait_frames(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL min_timeout: got no frame, want 1"); end
    checks++;
    if (cap_len.size() < 1 || cap_len[0] !== exp_len[0]) begin
      errors++;
      $display("FAIL min_len: got %0d want %0d", cap_len.size() > 0 ? cap_len[0] : -1, exp_len[0]);
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL min_bytes: got %0d bytes (diff at %0d) want %0d", cap_bytes.size(), d,
               exp_bytes.size());
    end
    checks++;
    if (hs_cnt !== 46 || und_cnt !== 0) begin
      errors++; $display("FAIL min_handshakes: got hs=%0d und=%0d want 46 0", hs_cnt, und_cnt);
    end
    stop_src();
  endtask

  task automatic test_pad();
    bit ok;
    int d;
    sel = 0; clear_all(); rand_hdr();
    exp_pl.push_back(8'hAB);
    src_q.push_back({1'b1, 8'hAB});
    add_frame(dest_mac, my_mac, etype, 4);
    go();
    wait_frames(1, ok);
    d = first_diff();
    checks++;
    if (!ok || cap_len[0] !== exp_len[0]) begin
      errors++;
      $display("FAIL pad_len: got %0d want %0d", ok ? cap_len[0] : -1, exp_len[0]);
    end
    checks++;
    if (d != -1) begin
      errors++; $display("FAIL pad_bytes: got diff at %0d want none", d);
    end
    checks++;
    if (hs_cnt !== 1) begin errors++; $display("FAIL pad_handshakes: got %0d want 1", hs_cnt); end
    stop_src();
  endtask

  task automatic test_n2_header();
    bit ok;
    int d;
    sel = 1; clear_all(); rand_hdr();
    dest_mac = 48'hFFFF_FFFF_FFFF;
    etype = 16'hF0F0;
    load_payload(100, 1);
    add_frame(dest_mac, my_mac, etype, 2);
    go();
    wait_frames(1, ok);
    d = first_diff();
    checks++;
    if (!ok || cap_len[0] !== exp_len[0]) begin
      errors++;
      $display("FAIL n2_len: got %0d want %0d", ok ? cap_len[0] : -1, exp_len[0]);
    end
    checks++;
    if (d != -1) begin errors++; $display("FAIL n2_bytes: got diff at %0d want none", d); end
    checks++;
    if (hs_cnt !== 100) begin errors++; $display("FAIL n2_handshakes: got %0d want 100", hs_cnt); end
    stop_src();
    sel = 0;
  endtask

  task automatic test_underrun();
    bit ok;
    int d;
    sel = 0; clear_all(); rand_hdr();
    load_payload(46, 1);
    while (exp_pl.size() > 10) void'(exp_pl.pop_back());
    add_frame(dest_mac, my_mac, etype, 4);
    go();
    src_budget = 10;
    wait_frames(1, ok);
    d = first_diff();
    checks++;
    if (!ok || cap_len[0] !== exp_len[0]) begin
      errors++;
      $display("FAIL und_len: got %0d want %0d", ok ? cap_len[0] : -1, exp_len[0]);
    end
    checks++;
    if (d != -1) begin errors++; $display("FAIL und_bytes: got diff at %0d want none", d); end
    checks++;
    if (und_cnt !== 1 || hs_cnt !== 10) begin
      errors++; $display("FAIL und_pulse: got und=%0d hs=%0d want 1 10", und_cnt, hs_cnt);
    end
    stop_src();
    // Source withdraws before the header ends: zero payload bytes.
    clear_all();
    load_payload(5, 1);
    exp_pl.delete();
    add_frame(dest_mac, my_mac, etype, 4);
    go();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axiov_m) break;
    end
    src_en = 0;
    wait_frames(1, ok);
    d = first_diff();
    checks++;
    if (!ok || d != -1 || cap_len[0] !== exp_len[0]) begin
      errors++;
      $display("FAIL und0_frame: got ok=%0d diff=%0d len=%0d want 1 -1 %0d", ok, d,
               ok ? cap_len[0] : -1, exp_len[0]);
    end
    checks++;
    if (und_cnt !== 1 || hs_cnt !== 0) begin
      errors++; $display("FAIL und0_pulse: got und=%0d hs=%0d want 1 0", und_cnt, hs_cnt);
    end
    stop_src();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    sel = 0; clear_all(); rand_hdr();
    load_payload(60, 1);
    add_frame(dest_mac, my_mac, etype, 4);
    exp_pl.delete();
    load_payload(60, 1);
    add_frame(dest_mac, my_mac, etype, 4);
    go();
    wait_frames(2, ok);
    d = first_diff();
    checks++;
    if (!ok || cap_len[0] !== exp_len[0] || cap_len[1] !== exp_len[1]) begin
      errors++;
      $display("FAIL b2b_len: got ok=%0d lens %0d %0d want %0d %0d", ok,
               cap_len.size() > 0 ? cap_len[0] : -1, cap_len.size() > 1 ? cap_len[1] : -1,
               exp_len[0], exp_len[1]);
    end
    checks++;
    if (gaps.size() < 1 || gaps[0] !== IfgBytes * 2 + 1) begin
      errors++;
      $display("FAIL b2b_gap: got %0d want %0d", gaps.size() > 0 ? gaps[0] : -1, IfgBytes * 2 + 1);
    end
    checks++;
    if (d != -1) begin errors++; $display("FAIL b2b_bytes: got diff at %0d want none", d); end
    checks++;
    if (hs_cnt !== 120) begin errors++; $display("FAIL b2b_handshakes: got %0d want 120", hs_cnt); end
    stop_src();
  endtask

  task automatic test_max_payload();
    bit ok;
    int d;
    sel = 0; clear_all(); rand_hdr();
    load_payload(MaxPl, 0);
    add_frame(dest_mac, my_mac, etype, 4);
    exp_pl.delete();
    load_payload(1, 1);
    add_frame(dest_mac, my_mac, etype, 4);
    go();
    wait_frames(2, ok);
    d = first_diff();
    checks++;
    if (!ok || cap_len[0] !== exp_len[0] || cap_len[1] !== exp_len[1]) begin
      errors++;
      $display("FAIL max_len: got ok=%0d lens %0d %0d want %0d %0d", ok,
               cap_len.size() > 0 ? cap_len[0] : -1, cap_len.size() > 1 ? cap_len[1] : -1,
               exp_len[0], exp_len[1]);
    end
    checks++;
    if (d != -1) begin errors++; $display("FAIL max_bytes: got diff at %0d want none", d); end
    checks++;
    if (hs_cnt !== MaxPl + 1 || und_cnt !== 0) begin
      errors++;
      $display("FAIL max_handshakes: got hs=%0d und=%0d want %0d 0", hs_cnt, und_cnt, MaxPl + 1);
    end
    stop_src();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d;
    sel = 0; clear_all(); rand_hdr();
    load_payload(60, 1);
    go();
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (hs_cnt >= 5) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: got hs=%0d want >=5", hs_cnt); end
    @(posedge clk); #2;
    rst = 1'b1; src_en = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axiov_m, busy_m, axiir_m, underrun_m, axiod_m} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outputs: got ov=%b busy=%b r=%b und=%b d=%h want all 0", axiov_m,
               busy_m, axiir_m, underrun_m, axiod_m);
    end
    src_q.delete();
    clear_all();
    repeat (3) @(negedge clk);
    load_payload(20, 1);
    add_frame(dest_mac, my_mac, etype, 4);
    go();
    wait_frames(1, ok);
    d = first_diff();
    checks++;
    if (!ok || d != -1 || cap_len[0] !== exp_len[0]) begin
      errors++;
      $display("FAIL rstmid_next_frame: got ok=%0d diff=%0d len=%0d want 1 -1 %0d", ok, d,
               ok ? cap_len[0] : -1, exp_len[0]);
    end
    stop_src();
  endtask

  task automatic test_random();
    bit ok;
    int d, len, n;
    for (int r = 0; r < 4; r++) begin
      sel = int'($urandom_range(0, 1));
      n = (sel == 1) ? 2 : 4;
      clear_all(); rand_hdr();
      len = int'($urandom_range(1, 80));
      load_payload(len, 1);
      add_frame(dest_mac, my_mac, etype, n);
      go();
      wait_frames(1, ok);
      d = first_diff();
      checks++;
      if (!ok || d != -1 || cap_len[0] !== exp_len[0] || hs_cnt !== len) begin
        errors++;
        $display("FAIL rand_frame%0d: got ok=%0d diff=%0d len=%0d hs=%0d want 1 -1 %0d %0d", r,
                 ok, d, ok ? cap_len[0] : -1, hs_cnt, exp_len[0], len);
      end
      stop_src();
    end
    sel = 0;
  endtask

  initial begin
    my_mac = '0; dest_mac = '0; etype = '0;
    test_reset();
    test_min_payload();
    test_pad();
    test_n2_header();
    test_underrun();
    test_back_to_back();
    test_max_payload();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
